alu_sched: RTL and testbench

Two-port request scheduler in front of the shared 8-bit ALU. It arbitrates between two requesters, port 0 (core execute stage) and port 1 (auxiliary/test requester), with a valid/ready request handshake. It drives the ALU for one cycle per granted operation, then returns a registered, flag-masked response on the granted port's response channel. It sits between the requesters and the combinational ALU, and is the only driver of the ALU inputs.

---
 rtl/alu_sched.sv | 210 +++++++++++++++++++++
 tb/tb_alu_sched.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sched.sv
//==============================================================================
// Module      : alu_sched
// Description : Two-port request scheduler in front of the shared 8-bit
//               combinational ALU. Arbitrates between port 0 (core execute
//               stage) and port 1 (auxiliary/test requester) with a
//               valid/ready handshake. Drives the ALU for exactly one cycle
//               per granted operation. Returns a registered, flag-masked
//               response on the granted port's response channel.
//
// Ports       : clk, reset_n               clock, async active-low reset
//               req_valid/req_ready [1:0]  per-port request handshake
//               req_op0/1, req_a0/1, req_b0/1  opcode and operands per port
//               rsp_valid/rsp_ready [1:0]  per-port response handshake
//               rsp_rslt, rsp_co/lt/z      shared registered result and flags
//               alu_op/a/b                 outputs to the ALU
//               alu_rslt/co/lt/z           inputs from the ALU
//               busy                       high whenever not IDLE
//
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

package definitions;
    localparam logic [4:0] kADD = 5'h00;
    localparam logic [4:0] kSUB = 5'h01;
    localparam logic [4:0] kAND = 5'h02;
    localparam logic [4:0] kOR  = 5'h03;
    localparam logic [4:0] kXOR = 5'h04;
    localparam logic [4:0] kMOV = 5'h05;
    localparam logic [4:0] kCMP = 5'h06;
endpackage

module alu_sched
    import definitions::*;
#(
    parameter bit RR = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,

    input  logic [1:0] req_valid,
    input  logic [4:0] req_op0,
    input  logic [4:0] req_op1,
    input  logic [7:0] req_a0,
    input  logic [7:0] req_a1,
    input  logic [7:0] req_b0,
    input  logic [7:0] req_b1,
    output logic [1:0] req_ready,

    output logic [1:0] rsp_valid,
    input  logic [1:0] rsp_ready,
    output logic [7:0] rsp_rslt,
    output logic       rsp_co,
    output logic       rsp_lt,
    output logic       rsp_z,

    output logic [4:0] alu_op,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    input  logic [7:0] alu_rslt,
    input  logic       alu_co,
    input  logic       alu_lt,
    input  logic       alu_z,

    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic       last_grant_q, last_grant_d;
    logic       grant_q, grant_d;      // port id of the operation in flight
    logic [4:0] op_q, op_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic [7:0] rslt_q, rslt_d;
    logic       co_q, co_d;
    logic       lt_q, lt_d;
    logic       z_q, z_d;

    logic       win;                   // port that would be granted this cycle
    logic [1:0] ready;
    logic       accept;
    logic       rsp_hs;

    //--------------------------------------------------------------------------
    // Arbitration. Only meaningful when at least one request is valid; the
    // ready mask below removes the grant when the winner is not requesting.
    //--------------------------------------------------------------------------
    if (RR) begin : g_rr
        // Contention goes to the port that did not win last time; otherwise
        // the single requesting port wins.
        assign win = (&req_valid) ? ~last_grant_q : req_valid[1];
    end else begin : g_fixed
        assign win = ~req_valid[0];
    end

    // reset_n gating keeps req_ready low while reset is held, even with the
    // state register already sitting in IDLE.
    always_comb begin
        ready = 2'b00;
        if ((state_q == ST_IDLE) && reset_n) begin
            ready = req_valid & (win ? 2'b10 : 2'b01);
        end
    end

    assign accept = |ready;
    assign rsp_hs = (state_q == ST_RESP) && rsp_ready[grant_q];

    //--------------------------------------------------------------------------
    // Next-state logic
    //--------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        rslt_d       = rslt_q;
        co_d         = co_q;
        lt_d         = lt_q;
        z_d          = z_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d      = ST_EXEC;
                    last_grant_d = win;
                    grant_d      = win;
                    op_d         = win ? req_op1 : req_op0;
                    a_d          = win ? req_a1  : req_a0;
                    b_d          = win ? req_b1  : req_b0;
                end
            end

            ST_EXEC: begin
                // Only the flags meaningful for the operation are passed on;
                // a compare reports through flags alone, so its result is zero.
                state_d = ST_RESP;
                rslt_d  = (op_q == kCMP) ? 8'h00 : alu_rslt;
                co_d    = (op_q == kADD) && alu_co;
                lt_d    = (op_q == kCMP) && alu_lt;
                z_d     = (op_q == kCMP) && alu_z;
            end

            ST_RESP: begin
                if (rsp_hs) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // State registers
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;          // port 0 wins the first contention
            grant_q      <= 1'b0;
            op_q         <= kMOV;
            a_q          <= 8'h00;
            b_q          <= 8'h00;
            rslt_q       <= 8'h00;
            co_q         <= 1'b0;
            lt_q         <= 1'b0;
            z_q          <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            rslt_q       <= rslt_d;
            co_q         <= co_d;
            lt_q         <= lt_d;
            z_q          <= z_d;
        end
    end

    //--------------------------------------------------------------------------
    // Outputs
    //--------------------------------------------------------------------------
    assign req_ready = ready;
    assign rsp_valid = (state_q == ST_RESP) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_rslt  = rslt_q;
    assign rsp_co    = co_q;
    assign rsp_lt    = lt_q;
    assign rsp_z     = z_q;
    assign busy      = (state_q != ST_IDLE);

    // Outside EXEC the ALU sees a harmless MOV of zero.
    assign alu_op = (state_q == ST_EXEC) ? op_q : kMOV;
    assign alu_a  = (state_q == ST_EXEC) ? a_q  : 8'h00;
    assign alu_b  = (state_q == ST_EXEC) ? b_q  : 8'h00;

endmodule

`default_nettype wire

// File: tb/tb_alu_sched.sv
//==============================================================================
// Module      : tb_alu_sched
// Description : Directed self-checking bench for alu_sched. One instance uses
//               round-robin arbitration, a second uses fixed priority. Each
//               has its own behavioural ALU.
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_alu_sched;
    import definitions::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Behavioural ALU: {co, lt, z, rslt}. Flags are produced for every op so
    // that the scheduler's masking is observable.
    function automatic logic [10:0] alu_model(input logic [4:0] op,
                                              input logic [7:0] a,
                                              input logic [7:0] b);
        logic [8:0] w;
        logic [7:0] r;
        logic       co;
        case (op)
            kADD:        w = {1'b0, a} + {1'b0, b};
            kSUB, kCMP:  w = {1'b0, a} - {1'b0, b};
            kMOV:        w = {1'b0, b};
            default:     w = {1'b0, a & b};
        endcase
        r  = w[7:0];
        co = w[8];
        return {co, (a < b), (r == 8'h00), r};
    endfunction

    // ---------------- round-robin instance ----------------
    logic [1:0] rr_req_valid, rr_req_ready, rr_rsp_valid, rr_rsp_ready;
    logic [4:0] rr_op0, rr_op1, rr_alu_op;
    logic [7:0] rr_a0, rr_a1, rr_b0, rr_b1, rr_rslt, rr_alu_a, rr_alu_b, rr_alu_rslt;
    logic       rr_co, rr_lt, rr_z, rr_alu_co, rr_alu_lt, rr_alu_z, rr_busy;

    always_comb {rr_alu_co, rr_alu_lt, rr_alu_z, rr_alu_rslt} = alu_model(rr_alu_op, rr_alu_a, rr_alu_b);

    alu_sched #(.RR(1'b1)) u_rr (
        .clk(clk), .reset_n(reset_n),
        .req_valid(rr_req_valid), .req_op0(rr_op0), .req_op1(rr_op1),
        .req_a0(rr_a0), .req_a1(rr_a1), .req_b0(rr_b0), .req_b1(rr_b1),
        .req_ready(rr_req_ready),
        .rsp_valid(rr_rsp_valid), .rsp_ready(rr_rsp_ready),
        .rsp_rslt(rr_rslt), .rsp_co(rr_co), .rsp_lt(rr_lt), .rsp_z(rr_z),
        .alu_op(rr_alu_op), .alu_a(rr_alu_a), .alu_b(rr_alu_b),
        .alu_rslt(rr_alu_rslt), .alu_co(rr_alu_co), .alu_lt(rr_alu_lt), .alu_z(rr_alu_z),
        .busy(rr_busy)
    );

    // ---------------- fixed-priority instance ----------------
    logic [1:0] fp_req_valid, fp_req_ready, fp_rsp_valid, fp_rsp_ready;
    logic [4:0] fp_op0, fp_op1, fp_alu_op;
    logic [7:0] fp_a0, fp_a1, fp_b0, fp_b1, fp_rslt, fp_alu_a, fp_alu_b, fp_alu_rslt;
    logic       fp_co, fp_lt, fp_z, fp_alu_co, fp_alu_lt, fp_alu_z, fp_busy;

    always_comb {fp_alu_co, fp_alu_lt, fp_alu_z, fp_alu_rslt} = alu_model(fp_alu_op, fp_alu_a, fp_alu_b);

    alu_sched #(.RR(1'b0)) u_fp (
        .clk(clk), .reset_n(reset_n),
        .req_valid(fp_req_valid), .req_op0(fp_op0), .req_op1(fp_op1),
        .req_a0(fp_a0), .req_a1(fp_a1), .req_b0(fp_b0), .req_b1(fp_b1),
        .req_ready(fp_req_ready),
        .rsp_valid(fp_rsp_valid), .rsp_ready(fp_rsp_ready),
        .rsp_rslt(fp_rslt), .rsp_co(fp_co), .rsp_lt(fp_lt), .rsp_z(fp_z),
        .alu_op(fp_alu_op), .alu_a(fp_alu_a), .alu_b(fp_alu_b),
        .alu_rslt(fp_alu_rslt), .alu_co(fp_alu_co), .alu_lt(fp_alu_lt), .alu_z(fp_alu_z),
        .busy(fp_busy)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rr_req_valid = 2'b11; rr_rsp_ready = 2'b00;
        rr_op0 = kMOV; rr_op1 = kMOV; rr_a0 = 8'h00; rr_a1 = 8'h00; rr_b0 = 8'h00; rr_b1 = 8'h00;
        fp_req_valid = 2'b00; fp_rsp_ready = 2'b00;
        fp_op0 = kMOV; fp_op1 = kMOV; fp_a0 = 8'h00; fp_a1 = 8'h00; fp_b0 = 8'h00; fp_b1 = 8'h00;

        // ---- reset values ----
        #2;
        chk("rst_req_ready", 16'(rr_req_ready), 16'(2'b00));
        chk("rst_rsp_valid", 16'(rr_rsp_valid), 16'(2'b00));
        chk("rst_rslt",      16'(rr_rslt),      16'(8'h00));
        chk("rst_flags",     16'({rr_co, rr_lt, rr_z}), 16'(3'b000));
        chk("rst_busy",      16'(rr_busy),      16'(1'b0));
        chk("rst_alu_op",    16'(rr_alu_op),    16'(kMOV));
        chk("rst_alu_ab",    16'({rr_alu_a, rr_alu_b}), 16'h0000);
        rr_req_valid = 2'b00;
        next_cycle;
        next_cycle;
        reset_n = 1'b1;

        // ---- ADD on port 0: 0xF0 + 0x20 ----
        rr_req_valid = 2'b01; rr_op0 = kADD; rr_a0 = 8'hF0; rr_b0 = 8'h20;
        #1;
        chk("add_ready", 16'(rr_req_ready), 16'(2'b01));
        chk("add_idle_busy", 16'(rr_busy), 16'(1'b0));
        next_cycle;                                  // EXEC
        rr_req_valid = 2'b00; rr_a0 = 8'h00;         // holding registers must keep F0
        #1;
        chk("add_exec_busy", 16'(rr_busy), 16'(1'b1));
        chk("add_exec_op",   16'(rr_alu_op), 16'(kADD));
        chk("add_exec_ab",   16'({rr_alu_a, rr_alu_b}), 16'hF020);
        chk("add_exec_rspv", 16'(rr_rsp_valid), 16'(2'b00));
        next_cycle;                                  // RESP
        #1;
        chk("add_rsp_valid", 16'(rr_rsp_valid), 16'(2'b01));
        chk("add_rsp_rslt",  16'(rr_rslt), 16'(8'h10));
        chk("add_rsp_flags", 16'({rr_co, rr_lt, rr_z}), 16'(3'b100));
        chk("add_rsp_aluop", 16'(rr_alu_op), 16'(kMOV));
        rr_rsp_ready = 2'b01;
        next_cycle;                                  // IDLE
        rr_rsp_ready = 2'b00;
        #1;
        chk("add_done_busy", 16'(rr_busy), 16'(1'b0));
        chk("add_done_rspv", 16'(rr_rsp_valid), 16'(2'b00));

        // ---- CMP on port 1: 5 vs 5 ----
        rr_req_valid = 2'b10; rr_op1 = kCMP; rr_a1 = 8'h05; rr_b1 = 8'h05;
        #1;
        chk("cmp1_ready", 16'(rr_req_ready), 16'(2'b10));
        next_cycle;                                  // EXEC
        rr_req_valid = 2'b00;
        #1;
        chk("cmp1_exec_op", 16'(rr_alu_op), 16'(kCMP));
        next_cycle;                                  // RESP
        rr_rsp_ready = 2'b01;                        // wrong port, ignored
        #1;
        chk("cmp1_rsp_valid", 16'(rr_rsp_valid), 16'(2'b10));
        chk("cmp1_rslt",      16'(rr_rslt), 16'(8'h00));
        chk("cmp1_flags",     16'({rr_co, rr_lt, rr_z}), 16'(3'b001));
        next_cycle;                                  // still RESP
        #1;
        chk("cmp1_ignore_busy", 16'(rr_busy), 16'(1'b1));
        chk("cmp1_ignore_rspv", 16'(rr_rsp_valid), 16'(2'b10));
        rr_rsp_ready = 2'b10;
        next_cycle;                                  // IDLE
        rr_rsp_ready = 2'b00;

        // ---- CMP on port 1: 3 vs 9 ----
        rr_req_valid = 2'b10; rr_a1 = 8'h03; rr_b1 = 8'h09;
        #1;
        chk("cmp2_ready", 16'(rr_req_ready), 16'(2'b10));
        next_cycle;
        rr_req_valid = 2'b00;
        next_cycle;                                  // RESP
        #1;
        chk("cmp2_rslt",  16'(rr_rslt), 16'(8'h00));
        chk("cmp2_flags", 16'({rr_co, rr_lt, rr_z}), 16'(3'b010));
        rr_rsp_ready = 2'b10;
        next_cycle;
        rr_rsp_ready = 2'b00;

        // ---- RR alternation, both ports continuously valid with SUB ----
        rr_op0 = kSUB; rr_a0 = 8'h09; rr_b0 = 8'h04;
        rr_op1 = kSUB; rr_a1 = 8'h00; rr_b1 = 8'h01;
        rr_req_valid = 2'b11; rr_rsp_ready = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_ready", 16'(rr_req_ready), (k % 2 == 1) ? 16'(2'b10) : 16'(2'b01));
            next_cycle;                              // EXEC
            #1;
            chk("rr_exec_a", 16'(rr_alu_a), (k % 2 == 1) ? 16'h0000 : 16'h0009);
            next_cycle;                              // RESP
            #1;
            chk("rr_rsp_valid", 16'(rr_rsp_valid), (k % 2 == 1) ? 16'(2'b10) : 16'(2'b01));
            chk("rr_rslt",      16'(rr_rslt), (k % 2 == 1) ? 16'h00FF : 16'h0005);
            chk("rr_flags",     16'({rr_co, rr_lt, rr_z}), 16'(3'b000));
            next_cycle;                              // IDLE
        end

        // ---- back-pressure: ADD 1+2 on port 0, port 1 also waiting ----
        rr_op0 = kADD; rr_a0 = 8'h01; rr_b0 = 8'h02; rr_rsp_ready = 2'b00;
        #1;
        chk("bp_ready", 16'(rr_req_ready), 16'(2'b01));
        next_cycle;                                  // EXEC
        next_cycle;                                  // RESP
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_rslt",  16'(rr_rslt), 16'h0003);
            chk("bp_ready_stall", 16'(rr_req_ready), 16'(2'b00));
            chk("bp_busy",  16'(rr_busy), 16'(1'b1));
            chk("bp_rspv",  16'(rr_rsp_valid), 16'(2'b01));
            next_cycle;
        end
        rr_rsp_ready = 2'b01;
        #1;
        chk("bp_release_rspv", 16'(rr_rsp_valid), 16'(2'b01));
        next_cycle;                                  // IDLE
        rr_rsp_ready = 2'b00;
        #1;
        chk("bp_idle_busy",  16'(rr_busy), 16'(1'b0));
        chk("bp_idle_ready", 16'(rr_req_ready), 16'(2'b10));
        rr_req_valid = 2'b00;                        // withdraw before the edge

        // ---- reset during EXEC ----
        rr_req_valid = 2'b01; rr_op0 = kADD; rr_a0 = 8'hF0; rr_b0 = 8'h20;
        #1;
        chk("rstx_ready", 16'(rr_req_ready), 16'(2'b01));
        next_cycle;                                  // EXEC
        rr_req_valid = 2'b00;
        #1;
        chk("rstx_exec_op", 16'(rr_alu_op), 16'(kADD));
        reset_n = 1'b0;
        #1;
        chk("rstx_busy",  16'(rr_busy), 16'(1'b0));
        chk("rstx_rslt",  16'(rr_rslt), 16'(8'h00));
        chk("rstx_aluop", 16'(rr_alu_op), 16'(kMOV));
        chk("rstx_alua",  16'(rr_alu_a), 16'(8'h00));
        chk("rstx_rspv",  16'(rr_rsp_valid), 16'(2'b00));
        next_cycle;
        next_cycle;
        reset_n = 1'b1;
        #1;
        chk("rstx_after_rspv", 16'(rr_rsp_valid), 16'(2'b00));
        next_cycle;
        #1;
        chk("rstx_after_rspv2", 16'(rr_rsp_valid), 16'(2'b00));
        rr_req_valid = 2'b11;
        #1;
        chk("rstx_contention", 16'(rr_req_ready), 16'(2'b01));
        rr_req_valid = 2'b00;

        // ---- fixed priority ----
        fp_op0 = kADD; fp_a0 = 8'h01; fp_b0 = 8'h01;
        fp_op1 = kMOV; fp_a1 = 8'h00; fp_b1 = 8'h5A;
        fp_req_valid = 2'b11; fp_rsp_ready = 2'b11;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("fp_ready", 16'(fp_req_ready), 16'(2'b01));
            next_cycle;
            next_cycle;
            #1;
            chk("fp_rspv", 16'(fp_rsp_valid), 16'(2'b01));
            chk("fp_rslt", 16'(fp_rslt), 16'h0002);
            next_cycle;
        end
        fp_req_valid = 2'b10;
        #1;
        chk("fp_p1_ready", 16'(fp_req_ready), 16'(2'b10));
        next_cycle;
        fp_req_valid = 2'b00;
        next_cycle;
        #1;
        chk("fp_p1_rspv", 16'(fp_rsp_valid), 16'(2'b10));
        chk("fp_p1_rslt", 16'(fp_rslt), 16'h005A);
        next_cycle;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
